// File: rtl/prm_edge_mask_accum.sv
// Obstacle-code front end and blocked-edge bitmap accumulator for the PRM checker bank.
// Codes are registered onto the shared checker inputs; returned masks are OR-ed and read out.
module prm_edge_mask_accum #(
  parameter int unsigned N_EDGES = 1024,
  parameter int unsigned CODE_W  = 15,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned N_WORDS = N_EDGES / OUT_W,
  localparam int unsigned IDX_W   = $clog2(N_WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CODE_W-1:0]  in_code,
  input  logic               in_last,
  output logic [CODE_W-1:0]  chk_code,
  input  logic [N_EDGES-1:0] edge_mask_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic [CNT_W-1:0]   obs_cnt
);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StOut} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_WORDS - 1);

  state_e             state_q, state_d;
  logic               v1_q, v2_q;
  logic [CODE_W-1:0]  code_q;
  logic [N_EDGES-1:0] edge_q;
  logic [N_EDGES-1:0] bitmap_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               rd_fire;
  logic               rd_done;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle, StAccum: begin
        in_ready = ~rst;
        if (in_valid && in_ready) begin
          state_d = in_last ? StDrain : StAccum;
        end
      end
      // S1 empty means the last beat sits in S2 and lands in the bitmap on this edge.
      StDrain: begin
        if (!v1_q) begin
          state_d = StOut;
        end
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready && (idx_q == LastIdx)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign out_last = out_valid & (idx_q == LastIdx);
  assign rd_fire  = out_valid & out_ready;
  assign rd_done  = rd_fire & out_last;
  assign out_data = out_valid ? bitmap_q[idx_q * OUT_W +: OUT_W] : '0;
  assign out_idx  = idx_q;
  assign chk_code = code_q;
  assign obs_cnt  = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Checker inputs only change on an accepted beat to avoid needless toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      edge_q <= '0;
    end else begin
      if (accept) begin
        code_q <= in_code;
      end
      v1_q <= accept;
      v2_q <= v1_q;
      if (v1_q) begin
        edge_q <= edge_mask_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else if (rd_done) begin
      bitmap_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      if (rd_fire) begin
        idx_q <= idx_q + 1'b1;
      end
      if (v2_q) begin
        bitmap_q <= bitmap_q | edge_q;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Bench for prm_edge_mask_accum: table vectors, random frames against a set-union model,
// backpressure, input gaps, frame turnaround and asynchronous reset during readout.
module tb_prm_edge_mask_accum;

  localparam int NE = 1024;
  localparam int CW = 15;
  localparam int OW = 32;
  localparam int NW = NE / OW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [CW-1:0] in_code, chk_code;
  logic [NE-1:0] edge_mask_in;
  logic          out_valid, out_ready, out_last;
  logic [OW-1:0] out_data;
  logic [4:0]    out_idx;
  logic [15:0]   obs_cnt;

  int            errors = 0;
  int            checks = 0;
  logic [NE-1:0] exp_bm;
  int            exp_cnt;

  always #5 clk = ~clk;

  prm_edge_mask_accum dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .in_last      (in_last),
    .chk_code     (chk_code),
    .edge_mask_in (edge_mask_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .obs_cnt      (obs_cnt)
  );

  // Stub checker bank: a fixed set of blocked edges per obstacle code.
  function automatic logic [NE-1:0] stub_mask(input logic [CW-1:0] c);
    logic [NE-1:0] m;
    int ci;
    m  = '0;
    ci = int'(c);
    case (c)
      15'h1234: m[5] = 1'b1;
      15'h0001: m[0] = 1'b1;
      15'h0002: m[33] = 1'b1;
      15'h0003: begin m[0] = 1'b1; m[1023] = 1'b1; end
      15'h0007: m[7] = 1'b1;
      default: begin
        m[(ci * 7) % NE]       = 1'b1;
        m[(ci * 131 + 3) % NE] = 1'b1;
        m[(ci >> 3) % NE]      = 1'b1;
      end
    endcase
    return m;
  endfunction

  always_comb edge_mask_in = stub_mask(chk_code);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Sends one frame, checks drain latency, then reads the bitmap out.
  // abort_idx >= 0 asserts reset (left asserted) while that word is presented.
  task automatic run_frame(input logic [CW-1:0] codes[$], input int gap, input int mode,
                           input int abort_idx, output logic [31:0] w0,
                           output logic [31:0] w1, output logic [31:0] w31);
    int n;
    int widx;
    bit done;
    bit stalled;
    logic [31:0] pd;
    logic [4:0] pi;
    logic [CW-1:0] lastc;
    exp_bm = '0;
    foreach (codes[i]) exp_bm |= stub_mask(codes[i]);
    exp_cnt = codes.size();
    w0 = '0;
    w1 = '0;
    w31 = '0;
    pd = '0;
    pi = '0;
    for (int i = 0; i < codes.size(); i++) begin
      if (gap > 0) begin
        repeat ($urandom_range(0, gap)) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_code  = CW'($urandom_range(0, 32767));
          #1;
          if (i > 0) check("chk_code_hold", chk_code, codes[i-1]);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_code  = codes[i];
      in_last  = (i == codes.size() - 1);
      #1;
      check("in_ready_accept", in_ready, 1'b1);
      @(posedge clk);
    end
    lastc = codes[codes.size()-1];
    n = 0;
    done = 1'b0;
    while (!done && n < 10) begin
      @(negedge clk);
      if (n == 0) begin
        in_valid = 1'b1;
        in_code  = 15'h5555;
        in_last  = 1'b1;
      end
      n++;
      #1;
      if (n == 1) check("in_ready_drain", in_ready, 1'b0);
      if (out_valid) done = 1'b1;
    end
    check("out_valid_latency", n, 3);
    check("obs_cnt", obs_cnt, exp_cnt);
    check("chk_code_last", chk_code, lastc);

    widx = 0;
    stalled = 1'b0;
    done = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      n++;
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = n[0];
      else out_ready = 1'($urandom_range(0, 1));
      if (widx > NW - 1) begin
        check("word_count", widx, NW - 1);
        done = 1'b1;
      end else begin
        check("out_valid", out_valid, 1'b1);
        check("out_idx", out_idx, widx[4:0]);
        check("out_data", out_data, exp_bm[widx*OW +: OW]);
        check("out_last", out_last, widx == NW - 1);
        check("chk_code_frozen", chk_code, lastc);
        if (stalled) begin
          check("stall_data", out_data, pd);
          check("stall_idx", out_idx, pi);
        end
        if (abort_idx >= 0 && widx == abort_idx) begin
          #1 rst = 1'b1;
          #1;
          check("rst_out_valid", out_valid, 1'b0);
          check("rst_out_data", out_data, 32'h0);
          check("rst_out_idx", out_idx, 5'd0);
          check("rst_obs_cnt", obs_cnt, 16'd0);
          check("rst_in_ready", in_ready, 1'b0);
          check("rst_chk_code", chk_code, 15'd0);
          in_valid  = 1'b0;
          in_last   = 1'b0;
          out_ready = 1'b0;
          done = 1'b1;
        end else begin
          if (out_ready) begin
            if (widx == 0) w0 = out_data;
            if (widx == 1) w1 = out_data;
            if (widx == NW - 1) w31 = out_data;
            if (out_last) begin
              in_valid = 1'b0;
              in_last  = 1'b0;
              done = 1'b1;
            end
            widx++;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            pd = out_data;
            pi = out_idx;
          end
          @(negedge clk);
          #1;
        end
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    if (abort_idx < 0) begin
      check("words_delivered", widx, NW);
      check("post_out_valid", out_valid, 1'b0);
      check("post_in_ready", in_ready, 1'b1);
      check("post_obs_cnt", obs_cnt, 16'd0);
    end
  endtask

  typedef struct packed {
    logic [3:0][CW-1:0] codes;
    int          n;
    int          gap;
    int          mode;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w31;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [CW-1:0] q[$];
    logic [31:0] w0, w1, w31;
    rst = 1'b1;
    in_valid = 1'b0;
    in_code = '0;
    in_last = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{codes: {15'h0, 15'h0, 15'h0, 15'h1234}, n: 1, gap: 0, mode: 0,
                w0: 32'h20, w1: 32'h0, w31: 32'h0};
    vecs[1] = '{codes: {15'h0, 15'h3, 15'h2, 15'h1}, n: 3, gap: 0, mode: 1,
                w0: 32'h1, w1: 32'h2, w31: 32'h8000_0000};
    vecs[2] = '{codes: {15'h0, 15'h3, 15'h2, 15'h1}, n: 3, gap: 3, mode: 2,
                w0: 32'h1, w1: 32'h2, w31: 32'h8000_0000};
    vecs[3] = '{codes: {15'h0, 15'h0, 15'h0, 15'h7}, n: 1, gap: 0, mode: 0,
                w0: 32'h80, w1: 32'h0, w31: 32'h0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_chk_code", chk_code, 15'd0);
    check("reset_obs_cnt", obs_cnt, 16'd0);
    check("reset_out_idx", out_idx, 5'd0);
    check("reset_out_last", out_last, 1'b0);
    check("reset_out_data", out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_in_ready", in_ready, 1'b1);

    for (int k = 0; k < 4; k++) begin
      q = {};
      for (int j = 0; j < vecs[k].n; j++) q.push_back(vecs[k].codes[j]);
      run_frame(q, vecs[k].gap, vecs[k].mode, -1, w0, w1, w31);
      check($sformatf("vec%0d_word0", k), w0, vecs[k].w0);
      check($sformatf("vec%0d_word1", k), w1, vecs[k].w1);
      check($sformatf("vec%0d_word31", k), w31, vecs[k].w31);
    end

    for (int f = 0; f < 6; f++) begin
      q = {};
      repeat ($urandom_range(1, 40)) q.push_back(CW'($urandom_range(0, 32767)));
      run_frame(q, int'($urandom_range(0, 3)), 2, -1, w0, w1, w31);
    end

    q = {};
    repeat (5) q.push_back(CW'($urandom_range(0, 32767)));
    run_frame(q, 1, 0, 10, w0, w1, w31);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_release_in_ready", in_ready, 1'b1);
    q = {};
    q.push_back(15'h0007);
    run_frame(q, 0, 1, -1, w0, w1, w31);
    check("after_abort_word0", w0, 32'h80);
    check("after_abort_word31", w31, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
